fp_align_stage: RTL and testbench
=================================

# fp_align_stage

Two-stage pipelined operand unpack/align stage for the single-precision floating-point adder/subtractor, sitting directly upstream of the mantissa add/sub datapath. It accepts raw IEEE 754 operands plus the add/sub select over a valid/ready handshake and classifies special operands. It swaps operands so the larger magnitude comes first, then right-shifts the smaller mantissa to the common exponent with guard/round/sticky bits. It delivers aligned 27-bit mantissas, the result exponent and effective signs, or a precomputed special result.

## Interface
- `WIDTH`, 32: operand width.
- `EXP_BITS`, 8: exponent width.
- `MANT_BITS`, 23: stored fraction width.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  stage accepts operands this cycle.
- `a`, `b`  in  WIDTH  IEEE 754 operands.
- `operation_select`  in  1  0 = a+b, 1 = a−b.
- `out_valid`  out  1  aligned result valid.
- `out_ready`  in  1  downstream consumes.
- `out_sign_big`, `out_sign_small`  out  1  effective signs of larger/smaller operand (b's sign pre-XORed with `operation_select`).
- `out_eff_sub`  out  1  `out_sign_big ^ out_sign_small`.
- `out_swapped`  out  1  b was the larger magnitude.
- `out_exp`  out  EXP_BITS  larger operand's effective exponent.
- `out_mant_big`, `out_mant_small`  out  MANT_BITS+4  {hidden, fraction, G, R, S}; small one aligned.
- `out_special`  out  1  `out_special_result` is final; mantissa outputs are don't-care.
- `out_special_result`  out  WIDTH  final packed result for special cases.

## Operation
- Effective b sign is `b[31] ^ operation_select`.
- Effective exponent is the stored exponent, or 1 if stored exponent is 0 (denormal).
- Hidden bit is `exp != 0`.
- Magnitude compare is an unsigned compare on bits [30:0]. Swap only when b > a; on equal magnitudes a stays big.
- Shift amount is `exp_big_eff − exp_small_eff`, EXP_BITS wide, unsigned.
- Alignment: small mantissa {hidden, frac, 3'b000} is logically right-shifted by the shift amount. The LSB of the result is ORed with the OR of all bits shifted out.
- Shift ≥ MANT_BITS+4: shifted value is 0, with LSB = OR of the whole input (sticky only).
- Special cases are evaluated in priority order:
  - Any NaN, or inf − inf (effective subtraction): result is 0x7FC00000.
  - Otherwise any inf: result is that inf, with its effective sign.
  - Both zero: result is ±0 with sign = `sign_a & sign_b_eff`.
  - In all three cases `out_special=1`. Nonzero finite operands set `out_special=0`.
- Stage 1 registers the unpack, classify, swap and shift amount.
- Stage 2 registers the shift result and passes the remaining fields through.

## Timing
- Latency is 2 cycles from input acceptance (`in_valid && in_ready`) to `out_valid`.
- Throughput is 1 operation/cycle while `out_ready=1`.
- Stall rules:
  - `s2_adv = !s2_valid || out_ready`.
  - `s1_adv = !s1_valid || s2_adv`.
  - `in_ready = s1_adv && !rst`.
  - These form a combinational ready chain; no bubbles are inserted.
- While `out_valid && !out_ready`, all outputs are held bit-stable.
- Up to 2 operations are buffered. The third is refused (`in_ready=0`) until `out_ready` rises.
- Reset: the cycle after `rst` is sampled high, `out_valid=0` and every data output is 0. `in_ready=0` while `rst=1` and 1 on the first cycle after deassertion.
- Reset mid-operation discards in-flight operations without emitting them.
- When `out_ready` and `in_valid` are both high with both stages full, the stage consumes, advances and accepts in the same cycle.

## Structure
- Package `fp_pkg`:
  - constants `EXP_BITS`, `MANT_BITS`, `QNAN = 32'h7FC00000`;
  - typedef `fp_class_t` enum {ZERO, DENORM, NORMAL, INF, NAN};
  - packed struct `align_s1_t` holding the stage-1 register contents.
- One combinational sub-module, `sticky_shifter`, parameterised by width. Its ports are input vector and shift amount; its output is the shifted vector with sticky folded into the LSB.

## Test plan
- Swap with small shift: `a=0x3FC00000` (1.5), `b=0x40000000`, op=0 → `out_swapped=1`, `out_exp=0x80`, `out_mant_big=0x4000000`, `out_mant_small=0x3000000`, `out_eff_sub=0`.
- Sticky on large shift:
  - `a=0x4B800000`, `b=0x3F800001`, op=0 → shift 24, `out_mant_small=0x0000005`.
  - `b=0x00000001` → `out_mant_small=0x0000001`.
- Specials:
  - `a=b=0x7F800000`, op=1 → `out_special=1`, result 0x7FC00000.
  - `a=0x80000000`, `b=0x00000000`, op=1 → result 0x80000000.
- Backpressure: issue 3 back-to-back ops, hold `out_ready=0` for 4 cycles. Required: outputs stable, `in_ready=0` on the third, and all 3 delivered in order with no loss or duplication after release.
- Equal magnitude, effective subtract: `a=b=0x40490FDB`, op=1 → `out_swapped=0`, `out_eff_sub=1`, mantissas equal.
- Reset with both stages full → next cycle `out_valid=0`, all outputs 0. After deassertion `in_ready=1` and the held operations never appear.

Source files
------------

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared constants, operand classes and stage-1 record for the fp align stage
package fp_pkg;

    localparam int EXP_BITS  = 8;
    localparam int MANT_BITS = 23;
    localparam int FP_WIDTH  = 1 + EXP_BITS + MANT_BITS;
    // {hidden, fraction, guard, round, sticky}
    localparam int ALIGN_W   = MANT_BITS + 4;

    localparam logic [FP_WIDTH-1:0] QNAN = 32'h7FC00000;

    typedef enum logic [2:0] {
        ZERO,
        DENORM,
        NORMAL,
        INF,
        NAN
    } fp_class_t;

    typedef struct packed {
        logic                sign_big;
        logic                sign_small;
        logic                swapped;
        logic [EXP_BITS-1:0] exp;
        logic [ALIGN_W-1:0]  mant_big;
        logic [ALIGN_W-1:0]  mant_small;
        logic [EXP_BITS-1:0] shamt;
        logic                special;
        logic [FP_WIDTH-1:0] special_result;
    } align_s1_t;

    function automatic fp_class_t classify(input logic [EXP_BITS-1:0]  e,
                                           input logic [MANT_BITS-1:0] f);
        if (e == '1) begin
            return (f == '0) ? INF : NAN;
        end
        if (e == '0) begin
            return (f == '0) ? ZERO : DENORM;
        end
        return NORMAL;
    endfunction

endpackage

// File: rtl/sticky_shifter.sv
// rtl/sticky_shifter.sv - logical right shift with shifted-out bits folded into the LSB
// data   : vector to shift
// shamt  : unsigned shift amount
// result : shifted vector, LSB ORed with every bit shifted out
module sticky_shifter #(
    parameter int W  = 27,
    parameter int SW = 8
) (
    input  logic [W-1:0]  data,
    input  logic [SW-1:0] shamt,
    output logic [W-1:0]  result
);

    logic [W-1:0] lost;

    always_comb begin
        result = '0;
        lost   = '0;
        if (32'(shamt) >= W) begin
            // everything falls off the end: only the sticky survives
            result[0] = |data;
        end else begin
            lost      = data & ~({W{1'b1}} << shamt);
            result    = data >> shamt;
            result[0] = result[0] | (|lost);
        end
    end

endmodule

// File: rtl/fp_align_stage.sv
// rtl/fp_align_stage.sv - two-stage unpack/classify/swap/align stage ahead of the fp mantissa adder
// clk, rst                      : clock, synchronous active-high reset
// in_valid/in_ready             : operand handshake for a, b, operation_select (1 = a-b)
// out_valid/out_ready           : result handshake
// out_sign_big/out_sign_small   : effective signs of larger/smaller magnitude operand
// out_eff_sub, out_swapped      : effective subtraction, b was larger
// out_exp                       : larger operand's effective exponent
// out_mant_big/out_mant_small   : {hidden, frac, G, R, S}, small one aligned
// out_special/out_special_result: final packed result for NaN/inf/zero-zero cases
module fp_align_stage #(
    parameter int WIDTH     = 32,
    parameter int EXP_BITS  = 8,
    parameter int MANT_BITS = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 operation_select,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sign_big,
    output logic                 out_sign_small,
    output logic                 out_eff_sub,
    output logic                 out_swapped,
    output logic [EXP_BITS-1:0]  out_exp,
    output logic [MANT_BITS+3:0] out_mant_big,
    output logic [MANT_BITS+3:0] out_mant_small,
    output logic                 out_special,
    output logic [WIDTH-1:0]     out_special_result
);

    import fp_pkg::*;

    localparam int MW = MANT_BITS + 4;

    logic                 sign_a, sign_b;
    logic [EXP_BITS-1:0]  exp_a, exp_b, exp_a_eff, exp_b_eff;
    logic [MANT_BITS-1:0] frac_a, frac_b;
    logic [MW-1:0]        mant_a, mant_b;
    fp_class_t            cls_a, cls_b;
    logic                 swap;
    align_s1_t            s1_d, s1_q;
    logic                 s1_valid;
    logic                 s1_adv, s2_adv;
    logic [MW-1:0]        mant_small_aligned;

    assign sign_a    = a[WIDTH-1];
    assign sign_b    = b[WIDTH-1] ^ operation_select;
    assign exp_a     = a[WIDTH-2 -: EXP_BITS];
    assign exp_b     = b[WIDTH-2 -: EXP_BITS];
    assign frac_a    = a[MANT_BITS-1:0];
    assign frac_b    = b[MANT_BITS-1:0];
    // denormals share the exponent of the smallest normal
    assign exp_a_eff = (exp_a == '0) ? EXP_BITS'(1) : exp_a;
    assign exp_b_eff = (exp_b == '0) ? EXP_BITS'(1) : exp_b;
    assign mant_a    = {exp_a != '0, frac_a, 3'b000};
    assign mant_b    = {exp_b != '0, frac_b, 3'b000};
    assign cls_a     = classify(exp_a, frac_a);
    assign cls_b     = classify(exp_b, frac_b);
    // exponent-then-fraction ordering makes the magnitude compare a plain integer compare
    assign swap      = b[WIDTH-2:0] > a[WIDTH-2:0];

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv && !rst;

    always_comb begin
        s1_d                = '0;
        s1_d.swapped        = swap;
        s1_d.sign_big       = swap ? sign_b : sign_a;
        s1_d.sign_small     = swap ? sign_a : sign_b;
        s1_d.exp            = swap ? exp_b_eff : exp_a_eff;
        s1_d.mant_big       = swap ? mant_b : mant_a;
        s1_d.mant_small     = swap ? mant_a : mant_b;
        s1_d.shamt          = swap ? (exp_b_eff - exp_a_eff) : (exp_a_eff - exp_b_eff);
        s1_d.special        = 1'b1;
        if (cls_a == NAN || cls_b == NAN || (cls_a == INF && cls_b == INF && sign_a != sign_b)) begin
            s1_d.special_result = QNAN;
        end else if (cls_a == INF) begin
            s1_d.special_result = {sign_a, a[WIDTH-2:0]};
        end else if (cls_b == INF) begin
            s1_d.special_result = {sign_b, b[WIDTH-2:0]};
        end else if (cls_a == ZERO && cls_b == ZERO) begin
            s1_d.special_result = {sign_a & sign_b, {(WIDTH-1){1'b0}}};
        end else begin
            s1_d.special        = 1'b0;
        end
    end

    sticky_shifter #(
        .W  (MW),
        .SW (EXP_BITS)
    ) u_shift (
        .data   (s1_q.mant_small),
        .shamt  (s1_q.shamt),
        .result (mant_small_aligned)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid           <= 1'b0;
            s1_q               <= '0;
            out_valid          <= 1'b0;
            out_sign_big       <= 1'b0;
            out_sign_small     <= 1'b0;
            out_eff_sub        <= 1'b0;
            out_swapped        <= 1'b0;
            out_exp            <= '0;
            out_mant_big       <= '0;
            out_mant_small     <= '0;
            out_special        <= 1'b0;
            out_special_result <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_q <= s1_d;
                end
            end
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_sign_big       <= s1_q.sign_big;
                    out_sign_small     <= s1_q.sign_small;
                    out_eff_sub        <= s1_q.sign_big ^ s1_q.sign_small;
                    out_swapped        <= s1_q.swapped;
                    out_exp            <= s1_q.exp;
                    out_mant_big       <= s1_q.mant_big;
                    out_mant_small     <= mant_small_aligned;
                    out_special        <= s1_q.special;
                    out_special_result <= s1_q.special_result;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_align_stage.sv
// tb/tb_fp_align_stage.sv - scoreboard bench for fp_align_stage
module tb_fp_align_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        op = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_sign_big, out_sign_small, out_eff_sub, out_swapped;
    logic [7:0]  out_exp;
    logic [26:0] out_mant_big, out_mant_small;
    logic        out_special;
    logic [31:0] out_special_result;

    fp_align_stage dut (
        .clk                (clk),
        .rst                (rst),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .a                  (a),
        .b                  (b),
        .operation_select   (op),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_sign_big       (out_sign_big),
        .out_sign_small     (out_sign_small),
        .out_eff_sub        (out_eff_sub),
        .out_swapped        (out_swapped),
        .out_exp            (out_exp),
        .out_mant_big       (out_mant_big),
        .out_mant_small     (out_mant_small),
        .out_special        (out_special),
        .out_special_result (out_special_result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sb, ss, sub, sw;
        logic [7:0]  e;
        logic [26:0] mb, ms;
        logic        sp;
        logic [31:0] sr;
    } exp_t;

    exp_t sbq[$];
    exp_t m_e;
    int   tests = 0;
    int   fails = 0;
    int   pops  = 0;
    bit   rand_rdy = 0;
    logic held = 1'b0;
    logic [98:0] snap;
    logic [98:0] cur;

    assign cur = {out_sign_big, out_sign_small, out_eff_sub, out_swapped, out_exp,
                  out_mant_big, out_mant_small, out_special, out_special_result};

    // Reference: operand values as integers, alignment as divide/remainder by 2^shift.
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic o);
        exp_t   r;
        int     ex, ey, exe, eye, s;
        longint mx, my, msm, res, pw;
        logic   sx, sy;
        bit     swap, nx, ny, ix, iy;
        sx  = x[31];
        sy  = y[31] ^ o;
        ex  = int'(x[30:23]);
        ey  = int'(y[30:23]);
        exe = (ex == 0) ? 1 : ex;
        eye = (ey == 0) ? 1 : ey;
        mx  = (longint'(ex != 0) * 64'd8388608 + longint'(x[22:0])) * 8;
        my  = (longint'(ey != 0) * 64'd8388608 + longint'(y[22:0])) * 8;
        swap = longint'(y[30:0]) > longint'(x[30:0]);
        r.sw = swap;
        if (swap) begin
            r.sb = sy; r.ss = sx; r.e = 8'(eye); r.mb = 27'(my); msm = mx; s = eye - exe;
        end else begin
            r.sb = sx; r.ss = sy; r.e = 8'(exe); r.mb = 27'(mx); msm = my; s = exe - eye;
        end
        r.sub = (sx != sy);
        if (s >= 27) begin
            res = (msm != 0) ? 1 : 0;
        end else begin
            pw  = longint'(1) << s;
            res = msm / pw;
            if (msm % pw != 0) res = res | 1;
        end
        r.ms = 27'(res);
        nx = (ex == 255) && (x[22:0] != 0);
        ny = (ey == 255) && (y[22:0] != 0);
        ix = (ex == 255) && (x[22:0] == 0);
        iy = (ey == 255) && (y[22:0] == 0);
        r.sp = 1'b1;
        r.sr = '0;
        if (nx || ny || (ix && iy && sx != sy)) r.sr = 32'h7FC00000;
        else if (ix) r.sr = {sx, 31'h7F800000};
        else if (iy) r.sr = {sy, 31'h7F800000};
        else if (x[30:0] == 0 && y[30:0] == 0) r.sr = {sx & sy, 31'd0};
        else r.sp = 1'b0;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                tests++;
                if (!out_valid || cur !== snap) begin
                    fails++;
                    $display("FAIL stall_hold: got valid=%0b data=0x%0h required valid=1 data=0x%0h",
                             out_valid, cur, snap);
                end
            end
            held = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    if (sbq.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_output: got out_valid=1 required no pending operation");
                    end else begin
                        m_e = sbq.pop_front();
                        pops++;
                        chk("sign_big",   32'(out_sign_big),   32'(m_e.sb));
                        chk("sign_small", 32'(out_sign_small), 32'(m_e.ss));
                        chk("eff_sub",    32'(out_eff_sub),    32'(m_e.sub));
                        chk("swapped",    32'(out_swapped),    32'(m_e.sw));
                        chk("exp",        32'(out_exp),        32'(m_e.e));
                        chk("special",    32'(out_special),    32'(m_e.sp));
                        if (m_e.sp) begin
                            chk("special_result", out_special_result, m_e.sr);
                        end else begin
                            chk("mant_big",   32'(out_mant_big),   32'(m_e.mb));
                            chk("mant_small", 32'(out_mant_small), 32'(m_e.ms));
                        end
                    end
                end else begin
                    held = 1'b1;
                    snap = cur;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic o);
        a = x; b = y; op = o; in_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready) begin
                sbq.push_back(model(x, y, o));
                tick();
                in_valid = 1'b0;
                return;
            end
            tick();
        end
        tests++;
        fails++;
        $display("FAIL send_timeout: got in_ready=0 for 100 cycles required acceptance");
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) return;
        end
        tests++;
        fails++;
        $display("FAIL out_timeout: got out_valid=0 for 20 cycles required 1");
    endtask

    function automatic logic [31:0] rnd_op(input logic [31:0] other);
        logic        s;
        logic [22:0] f;
        s = 1'($urandom());
        f = 23'($urandom());
        case ($urandom_range(0, 9))
            0:       return {s, 31'd0};
            1:       return {s, 8'hFF, 23'd0};
            2:       return {s, 8'hFF, f | 23'd1};
            3:       return {s, 8'h00, f};
            4:       return {s, other[30:0]};
            5, 6:    return {s, 8'(other[30:23] + 8'($urandom_range(0, 30))), f};
            default: return {s, 8'($urandom_range(1, 254)), f};
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish required finish within time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] x, y;
        int          p0;

        repeat (3) tick();
        @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        chk("reset_mant_big", 32'(out_mant_big), 32'd0);
        chk("reset_special_result", out_special_result, 32'd0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", 32'(in_ready), 32'd1);
        tick();

        send(32'h3FC00000, 32'h40000000, 1'b0);
        wait_out();
        chk("swap_swapped", 32'(out_swapped), 32'd1);
        chk("swap_exp", 32'(out_exp), 32'h80);
        chk("swap_mant_big", 32'(out_mant_big), 32'h4000000);
        chk("swap_mant_small", 32'(out_mant_small), 32'h3000000);
        chk("swap_eff_sub", 32'(out_eff_sub), 32'd0);
        tick();

        send(32'h4B800000, 32'h3F800001, 1'b0);
        wait_out();
        chk("sticky_shift24", 32'(out_mant_small), 32'h0000005);
        tick();

        send(32'h4B800000, 32'h00000001, 1'b0);
        wait_out();
        chk("sticky_only", 32'(out_mant_small), 32'h0000001);
        tick();

        send(32'h7F800000, 32'h7F800000, 1'b1);
        wait_out();
        chk("inf_minus_inf_flag", 32'(out_special), 32'd1);
        chk("inf_minus_inf_result", out_special_result, 32'h7FC00000);
        tick();

        send(32'h80000000, 32'h00000000, 1'b1);
        wait_out();
        chk("neg_zero_flag", 32'(out_special), 32'd1);
        chk("neg_zero_result", out_special_result, 32'h80000000);
        tick();

        send(32'h40490FDB, 32'h40490FDB, 1'b1);
        wait_out();
        chk("equal_swapped", 32'(out_swapped), 32'd0);
        chk("equal_eff_sub", 32'(out_eff_sub), 32'd1);
        chk("equal_mant_big", 32'(out_mant_big), 32'h6487ED8);
        chk("equal_mant_small", 32'(out_mant_small), 32'h6487ED8);
        tick();

        // backpressure: two buffered, third refused until release
        out_ready = 1'b0;
        p0 = pops;
        send(32'h3F800000, 32'h40400000, 1'b0);
        send(32'hC1200000, 32'h3E800000, 1'b1);
        a = 32'h42F60000; b = 32'hC2F60000; op = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("third_refused", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        send(32'h42F60000, 32'hC2F60000, 1'b0);
        for (int k = 0; k < 20 && sbq.size() != 0; k++) tick();
        chk("backpressure_delivered", 32'(pops - p0), 32'd3);

        // reset with both stages full
        out_ready = 1'b0;
        send(32'h40A00000, 32'h40200000, 1'b0);
        send(32'hBF000000, 32'h7F800000, 1'b0);
        p0 = pops;
        rst = 1'b1;
        sbq.delete();
        @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_exp", 32'(out_exp), 32'd0);
        chk("rst_mant_small", 32'(out_mant_small), 32'd0);
        chk("rst_special", 32'(out_special), 32'd0);
        chk("rst_special_result", out_special_result, 32'd0);
        chk("rst_swapped", 32'(out_swapped), 32'd0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_release_in_ready", 32'(in_ready), 32'd1);
        repeat (8) tick();
        chk("rst_discarded", 32'(pops - p0), 32'd0);

        // randomized traffic with random backpressure
        rand_rdy = 1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                tick();
            end else begin
                x = rnd_op(32'($urandom()));
                y = rnd_op(x);
                send(x, y, 1'($urandom()));
            end
        end
        rand_rdy = 0;
        tick();
        out_ready = 1'b1;
        for (int k = 0; k < 50 && sbq.size() != 0; k++) tick();
        chk("drain_empty", 32'(sbq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
